rpe_dbuf: RTL

Parametrised reduced-precision systolic processing element: the next generation of the team's weight-stationary RPE. It adds double-buffered weights, so a new weight set can shift in while the MAC keeps computing. It also adds registered valid handshakes on the activation, partial-sum and weight paths, a propagated weight-swap wavefront, and an optional saturating accumulator. One instance sits at every (row, column) node of the SIZE×SIZE array: activations flow right, weights and partial sums flow down.

---
 rtl/rpe_dbuf.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rpe_dbuf.sv
`default_nettype none
// ============================================================================
// Module   : rpe_dbuf
// Purpose  : Weight-stationary reduced-precision systolic processing element
//            with double-buffered weights. A shadow weight shifts down the
//            column while the active weight feeds the MAC. A registered swap
//            wavefront copies shadow to active. Activations flow right,
//            weights and partial sums flow down. Every path has one cycle of
//            latency.
// Ports    : clk, rst                      clock / async active-high reset
//            weight_in, weight_in_valid    weight load beat from PE above
//            weight_out, weight_out_valid  weight chain to PE below
//            swap_in / swap_out            shadow->active swap wavefront
//            act_in, act_valid_in          activation (and psum) beat, left
//            act_out, act_valid_out        activation to PE on the right
//            psum_in / psum_out            signed partial sum, above/below
//            psum_sat                      current psum_out was clamped
// Options  : `define RPE_PSUM_SAT_EN to enable the saturating accumulator.
//            Without it, psum_out wraps and psum_sat is tied low.
// Revision : 1.0  initial release
// ============================================================================
module rpe_dbuf #(
  parameter int SIZE   = 8,
  parameter int ACT_W  = 7,
  parameter int WGT_W  = 4,
  parameter int PSUM_W = (ACT_W + 1) + WGT_W + 4 + $clog2(SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WGT_W:0]           weight_in,
  input  logic                     weight_in_valid,
  output logic [WGT_W:0]           weight_out,
  output logic                     weight_out_valid,
  input  logic                     swap_in,
  output logic                     swap_out,
  input  logic [ACT_W-1:0]         act_in,
  input  logic                     act_valid_in,
  output logic [ACT_W-1:0]         act_out,
  output logic                     act_valid_out,
  input  logic signed [PSUM_W-1:0] psum_in,
  output logic signed [PSUM_W-1:0] psum_out,
  output logic                     psum_sat
);

  // Working width of the multiply/add. The saturating build needs one guard
  // bit to detect overflow; the wrapping build works directly in PSUM_W.
`ifdef RPE_PSUM_SAT_EN
  localparam int c_SUM_W = PSUM_W + 1;
`else
  localparam int c_SUM_W = PSUM_W;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WGT_W:0]           r_wsh;
  logic [WGT_W:0]           r_wact;
  logic [WGT_W:0]           r_weight_out;
  logic                     r_weight_out_valid;
  logic                     r_swap_out;
  logic [ACT_W-1:0]         r_act_out;
  logic                     r_act_valid_out;
  logic signed [PSUM_W-1:0] r_psum_out;
  logic                     r_psum_sat;

  // --------------------------------------------------------------------------
  // Weight decode and product
  // --------------------------------------------------------------------------
  logic                      w_flag;
  logic signed [WGT_W-1:0]   w_sv;
  logic signed [WGT_W-1:0]   w_m;
  logic signed [ACT_W:0]     w_a;
  logic signed [c_SUM_W-1:0] w_a_ext;
  logic signed [c_SUM_W-1:0] w_q_ext;
  logic signed [c_SUM_W-1:0] w_p;
  logic signed [c_SUM_W-1:0] w_sum;
  logic signed [PSUM_W-1:0]  w_psum_next;
  logic                      w_ovf;

  assign w_flag = r_wact[WGT_W];
  assign w_sv   = r_wact[WGT_W-1:0];

  // Flagged codes use a magnitude-symmetric multiplier: negative fields move
  // one step toward zero, so -1 encodes zero and the range stays +/-(2^(W-1)-1).
  assign w_m = w_sv[WGT_W-1] ? (w_sv + {{(WGT_W-1){1'b0}}, 1'b1}) : w_sv;

  // The stored activation has an implicit trailing 1, so it is always odd.
  assign w_a     = {act_in, 1'b1};
  assign w_a_ext = {{(c_SUM_W-ACT_W-1){w_a[ACT_W]}}, w_a};

  // F=0 : q = 2*sV+1, which is {sV, 1}
  // F=1 : q = m * 2^WGT_W, which is {m, WGT_W zeros}
  assign w_q_ext = w_flag
                 ? {{(c_SUM_W-2*WGT_W){w_m[WGT_W-1]}}, w_m, {WGT_W{1'b0}}}
                 : {{(c_SUM_W-WGT_W-1){w_sv[WGT_W-1]}}, w_sv, 1'b1};

  // The true product fits well inside c_SUM_W, so the truncated signed
  // multiply is exact.
  assign w_p = w_a_ext * w_q_ext;

`ifdef RPE_PSUM_SAT_EN
  localparam logic [PSUM_W-1:0] c_PSUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic [PSUM_W-1:0] c_PSUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

  assign w_sum = {psum_in[PSUM_W-1], psum_in} + w_p;
  // Overflow when the guard bit disagrees with the PSUM_W sign bit.
  assign w_ovf = w_sum[c_SUM_W-1] ^ w_sum[PSUM_W-1];
  assign w_psum_next = !w_ovf             ? w_sum[PSUM_W-1:0]
                     : w_sum[c_SUM_W-1]   ? c_PSUM_MIN
                     :                      c_PSUM_MAX;
`else
  assign w_sum       = psum_in + w_p;
  assign w_ovf       = 1'b0;
  assign w_psum_next = w_sum;
`endif

  // --------------------------------------------------------------------------
  // Weight chain and swap wavefront
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wsh              <= '0;
      r_wact             <= '0;
      r_weight_out       <= '0;
      r_weight_out_valid <= 1'b0;
      r_swap_out         <= 1'b0;
    end else begin
      if (weight_in_valid) begin
        r_wsh        <= weight_in;
        r_weight_out <= r_wsh;
      end
      // Uses the pre-edge shadow, so a load on the same edge lands in the
      // shadow while the previous shadow becomes active.
      if (swap_in) begin
        r_wact <= r_wsh;
      end
      r_weight_out_valid <= weight_in_valid;
      r_swap_out         <= swap_in;
    end
  end

  // --------------------------------------------------------------------------
  // Activation / partial-sum datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_out       <= '0;
      r_act_valid_out <= 1'b0;
      r_psum_out      <= '0;
      r_psum_sat      <= 1'b0;
    end else begin
      r_act_valid_out <= act_valid_in;
      // The flag marks only the beat that was clamped.
      r_psum_sat      <= act_valid_in & w_ovf;
      if (act_valid_in) begin
        r_act_out  <= act_in;
        r_psum_out <= w_psum_next;
      end
    end
  end

  assign weight_out       = r_weight_out;
  assign weight_out_valid = r_weight_out_valid;
  assign swap_out         = r_swap_out;
  assign act_out          = r_act_out;
  assign act_valid_out    = r_act_valid_out;
  assign psum_out         = r_psum_out;
  assign psum_sat         = r_psum_sat;

endmodule
`default_nettype wire
